// File: rtl/uart_rx_capture.sv
// UART receive channel with first-word fall-through capture FIFO.
// Frame format, baud divisor and buffer depth are fixed by parameters.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for synchronised rx to go low
// START     | half-bit wait, confirm start bit is still low
// DATA      | sampling DATA_BITS data bits, LSB first
// PARITY    | sampling the parity bit (only when PARITY != 0)
// STOP      | sampling STOP_BITS stop bits, push entry on the last one
// WAIT_HIGH | after a frame error, wait for the line to return high
module uart_rx_capture #(
    parameter int BAUD_DIV   = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic                            rx_i,
    input  logic                            rd_en_i,
    input  logic                            clr_err_i,
    output logic [7:0]                      data_o,
    output logic                            fe_o,
    output logic                            pe_o,
    output logic                            empty_o,
    output logic                            full_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
    output logic                            overrun_o,
    output logic                            break_o
);

    localparam int CW   = $clog2(BAUD_DIV);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0]   HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0]   FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [2:0]      LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            rxs;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            fe_q, fe_d;
    logic            break_q, break_d;
    logic            tick;
    logic            fe_now;
    logic            par_exp;
    logic            push;
    logic            push_fe;
    logic            push_pe;

    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            empty_q, full_q;
    logic            overrun_q, overrun_d;
    logic            do_wr, do_rd, drop;
    logic [9:0]      head;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rxs  = sync2_q;
    assign tick = (baud_q == '0);

    // Expected parity bit over the captured data; unused upper bits are zero.
    assign par_exp = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

    // Receiver state and datapath registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            fe_q    <= 1'b0;
            break_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            fe_q    <= fe_d;
            break_q <= break_d;
        end
    end

    // Next-state logic: bit timing, sampling and the push request.
    always_comb begin
        state_d = state_q;
        baud_d  = (baud_q != '0) ? baud_q - CW'(1) : baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        fe_d    = fe_q;
        break_d = break_q;
        push    = 1'b0;
        push_fe = 1'b0;
        push_pe = 1'b0;
        fe_now  = fe_q | ~rxs;

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    baud_d  = HALF_LOAD;
                    shift_d = '0;
                    par_d   = 1'b0;
                    fe_d    = 1'b0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rxs) begin
                        // Glitch shorter than half a bit: not a real start.
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        baud_d  = FULL_LOAD;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d[bit_q] = rxs;
                    baud_d         = FULL_LOAD;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    par_d   = rxs;
                    baud_d  = FULL_LOAD;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        push    = 1'b1;
                        push_fe = fe_now;
                        push_pe = (PARITY != 0) && (par_q != par_exp);
                        if (fe_now) begin
                            state_d = S_WAIT_HIGH;
                            // All-zero frame, including parity, means a held-low line.
                            if ((shift_q == '0) && ((PARITY == 0) || !par_q)) begin
                                break_d = 1'b1;
                            end
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        fe_d   = fe_now;
                        bit_d  = bit_q + 3'd1;
                        baud_d = FULL_LOAD;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = S_IDLE;
                    break_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A read on an empty FIFO is ignored; a write on a full FIFO only
    // proceeds when a read frees the head slot in the same cycle.
    always_comb begin
        do_rd   = rd_en_i && !empty_q;
        do_wr   = push && (!full_q || do_rd);
        drop    = push && full_q && !do_rd;
        count_d = count_q + CNTW'(do_wr) - CNTW'(do_rd);
        overrun_d = overrun_q;
        if (clr_err_i) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    // FIFO pointers, occupancy and sticky overrun flag.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == DEPTH_CNT);
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage, entry layout {fe, pe, data}.
    always_ff @(posedge wb_clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= {push_fe, push_pe, shift_q};
        end
    end

    // Head is masked to zero while empty so outputs are defined out of reset.
    assign head      = empty_q ? 10'd0 : mem_q[rd_ptr_q];
    assign data_o    = head[7:0];
    assign pe_o      = head[8];
    assign fe_o      = head[9];
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign count_o   = count_q;
    assign overrun_o = overrun_q;
    assign break_o   = break_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: an 8N1 instance and a 7E1 instance,
// with expected FIFO entries queued as frames are sent and checked on pop.
module tb_uart_rx_capture;

    localparam int BD = 16;

    logic       clk;
    logic       rst_n;
    logic       rx_a, rd_a, clr_a;
    logic       rx_b, rd_b, clr_b;

    logic [7:0] data_a, data_b;
    logic       fe_a, pe_a, empty_a, full_a, ovr_a, brk_a;
    logic       fe_b, pe_b, empty_b, full_b, ovr_b, brk_b;
    logic [4:0] count_a;
    logic [2:0] count_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    uart_rx_capture #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .rx_i     (rx_a),
        .rd_en_i  (rd_a),
        .clr_err_i(clr_a),
        .data_o   (data_a),
        .fe_o     (fe_a),
        .pe_o     (pe_a),
        .empty_o  (empty_a),
        .full_o   (full_a),
        .count_o  (count_a),
        .overrun_o(ovr_a),
        .break_o  (brk_a)
    );

    uart_rx_capture #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .rx_i     (rx_b),
        .rd_en_i  (rd_b),
        .clr_err_i(clr_b),
        .data_o   (data_b),
        .fe_o     (fe_b),
        .pe_o     (pe_b),
        .empty_o  (empty_b),
        .full_o   (full_b),
        .count_o  (count_b),
        .overrun_o(ovr_b),
        .break_o  (brk_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    // Drives one frame starting at the current negedge, one bit per BD clocks.
    task automatic send(input bit which, input logic [7:0] d, input int nbits,
                        input bit has_par, input logic par_bit, input logic stop_bit);
        set_rx(which, 1'b0);
        repeat (BD) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, d[i]);
            repeat (BD) @(negedge clk);
        end
        if (has_par) begin
            set_rx(which, par_bit);
            repeat (BD) @(negedge clk);
        end
        set_rx(which, stop_bit);
        repeat (BD) @(negedge clk);
        set_rx(which, 1'b1);
    endtask

    // 8N1 frame on instance A; scoreboard drops the entry if the model is full.
    task automatic send_a(input logic [7:0] d);
        if (q_a.size() < 16) q_a.push_back({1'b0, 1'b0, d});
        send(1'b0, d, 8, 1'b0, 1'b0, 1'b1);
    endtask

    // 7E1 frame on instance B with an explicit parity bit.
    task automatic send_b(input logic [6:0] d, input logic par_bit);
        logic pe;
        pe = (^d) ^ par_bit;
        q_b.push_back({1'b0, pe, 1'b0, d});
        send(1'b1, {1'b0, d}, 7, 1'b1, par_bit, 1'b1);
    endtask

    task automatic read_check(input bit which, input string tag);
        logic [9:0] e;
        if (which == 1'b0) begin
            if (q_a.size() == 0) begin
                check({tag, "_sb_empty"}, empty_a, 1);
                return;
            end
            e = q_a.pop_front();
            check({tag, "_data"}, data_a, e[7:0]);
            check({tag, "_pe"}, pe_a, e[8]);
            check({tag, "_fe"}, fe_a, e[9]);
            rd_a = 1'b1;
            @(negedge clk);
            rd_a = 1'b0;
        end else begin
            if (q_b.size() == 0) begin
                check({tag, "_sb_empty"}, empty_b, 1);
                return;
            end
            e = q_b.pop_front();
            check({tag, "_data"}, data_b, e[7:0]);
            check({tag, "_pe"}, pe_b, e[8]);
            check({tag, "_fe"}, fe_b, e[9]);
            rd_b = 1'b1;
            @(negedge clk);
            rd_b = 1'b0;
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_data"}, data_a, 0);
        check({tag, "_fe"}, fe_a, 0);
        check({tag, "_pe"}, pe_a, 0);
        check({tag, "_empty"}, empty_a, 1);
        check({tag, "_full"}, full_a, 0);
        check({tag, "_count"}, count_a, 0);
        check({tag, "_overrun"}, ovr_a, 0);
        check({tag, "_break"}, brk_a, 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        rx_a = 1'b1; rd_a = 1'b0; clr_a = 1'b0;
        rx_b = 1'b1; rd_b = 1'b0; clr_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        check("rst_b_empty", empty_b, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 8N1 0xA5 with exact empty_o latency from the rx_i edge
        k = 0;
        fork
            send_a(8'hA5);
            begin
                while (k <= 400 && empty_a) begin
                    @(negedge clk);
                    k++;
                end
            end
        join
        check("t1_latency", k, 155);
        check("t1_count", count_a, 1);
        read_check(1'b0, "t1_head");
        check("t1_empty_after_pop", empty_a, 1);

        // 2: 7E1, wrong parity then correct parity
        send_b(7'h03, 1'b1);
        send_b(7'h03, 1'b0);
        check("t2_count", count_b, 2);
        read_check(1'b1, "t2_bad_par");
        read_check(1'b1, "t2_good_par");
        check("t2_empty", empty_b, 1);

        // 3: short low pulse is a false start; next frame still decodes
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("t3_count", count_a, 0);
        check("t3_empty", empty_a, 1);
        send_a(8'h5A);
        read_check(1'b0, "t3_head");

        // 4: overflow a 16-entry FIFO with 17 frames
        for (int v = 0; v <= 16; v++) send_a(8'(v));
        check("t4_count", count_a, 16);
        check("t4_full", full_a, 1);
        check("t4_overrun", ovr_a, 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("t4_overrun_clr", ovr_a, 0);
        for (int v = 0; v < 16; v++) read_check(1'b0, "t4_head");
        check("t4_empty", empty_a, 1);
        check("t4_full_after", full_a, 0);

        // 5: line held low for 20 bit times -> one break entry
        q_a.push_back({1'b1, 1'b0, 8'h00});
        rx_a = 1'b0;
        repeat (20 * BD) @(negedge clk);
        check("t5_count", count_a, 1);
        check("t5_break", brk_a, 1);
        check("t5_head_fe", fe_a, 1);
        rx_a = 1'b1;
        @(negedge clk);
        check("t5_break_hold1", brk_a, 1);
        @(negedge clk);
        check("t5_break_hold2", brk_a, 1);
        @(negedge clk);
        check("t5_break_clr", brk_a, 0);
        repeat (12 * BD) @(negedge clk);
        check("t5_one_entry", count_a, 1);
        read_check(1'b0, "t5_head");
        check("t5_empty", empty_a, 1);

        // 6: reset in the middle of a frame with an entry already stored
        send_a(8'h77);
        check("t6_pre_count", count_a, 1);
        rx_a = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        @(negedge clk);
        check_reset_a("t6_rst");
        rst_n = 1'b1;
        q_a.delete();
        repeat (12 * BD) @(negedge clk);
        check("t6_no_partial", count_a, 0);
        send_a(8'h3C);
        read_check(1'b0, "t6_head");
        check("t6_empty", empty_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
